// File: rtl/pll_rst_seq_pkg.sv
// Shared state and cause encodings for the PLL reset sequencer.
package pll_rst_seq_pkg;

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_LOCK_WAIT = 2'd1,
    S_SYS_HOLD  = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_KEY  = 2'd1,
    CAUSE_SOFT = 2'd2
  } cause_t;

  localparam logic [7:0] RST_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/pll_rst_seq_key_debounce.sv
// Pushbutton conditioner: 2-FF synchroniser, stability counter and press pulse.
module key_debounce
  import pll_rst_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter int CNT_W        = 18
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic key_db,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             db_q, db_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced level disagrees with the debounced
  // level, so any bounce back to the old level restarts the stability window.
  always_comb begin
    s1_d    = key_n;
    s2_d    = s1_q;
    db_d    = db_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (s2_q != db_q) begin
      if (cnt_q == DEB_LAST) begin
        db_d    = s2_q;
        press_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      db_q    <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign key_db    = db_q;
  assign press_evt = press_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: PLL reset pulse, blind lock wait, SoC reset hold, then run.
//
//  state       | meaning
//  S_PLL_RST   | pll_rst asserted; waits minimum time and debounced key release
//  S_LOCK_WAIT | pll_rst released; fixed settle time (PLL has no lock flag)
//  S_SYS_HOLD  | extra hold of sys_rst_n after settle
//  S_RUN       | sys_rst_n released, ready high
module pll_rst_seq
  import pll_rst_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 250000,
  parameter int PLL_RST_CYC   = 16,
  parameter int LOCK_WAIT_CYC = 2500,
  parameter int SYS_HOLD_CYC  = 64,
  parameter int CNT_W         = 18
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_n,
  input  logic       soft_rst_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [1:0] rst_cause,
  output logic [7:0] rst_count
);

  localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SYS_HOLD_CYC - 1);

  logic key_db, press_evt, soft_edge, restart;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_key_debounce (
    .clk      (clk),
    .resetn   (resetn),
    .key_n    (key_n),
    .key_db   (key_db),
    .press_evt(press_evt)
  );

  state_t           state_q, state_d;
  cause_t           cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       count_q, count_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_n_q, sys_rst_n_d;
  logic             ready_q, ready_d;
  logic             soft_s1_q, soft_s1_d;
  logic             soft_s2_q, soft_s2_d;
  logic             soft_s3_q, soft_s3_d;

  assign soft_edge = soft_s2_q & ~soft_s3_q;
  assign restart   = press_evt | soft_edge;

  always_comb begin
    soft_s1_d = soft_rst_req;
    soft_s2_d = soft_s1_q;
    soft_s3_d = soft_s2_q;
    state_d   = state_q;
    cause_d   = cause_q;
    count_d   = count_q;
    cnt_d     = cnt_q + 1'b1;

    case (state_q)
      S_PLL_RST: begin
        // Minimum time elapsed: hold the count and wait for the key to let go.
        if (cnt_q >= PLL_LAST) begin
          cnt_d = cnt_q;
          if (key_db) begin
            state_d = S_LOCK_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_LOCK_WAIT: begin
        if (cnt_q == LOCK_LAST) begin
          state_d = S_SYS_HOLD;
          cnt_d   = '0;
        end
      end
      S_SYS_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN:   cnt_d = '0;
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    if (restart) begin
      state_d = S_PLL_RST;
      cnt_d   = '0;
      cause_d = press_evt ? CAUSE_KEY : CAUSE_SOFT;
      if (count_q != RST_COUNT_MAX) count_d = count_q + 8'd1;
    end

    pll_rst_d   = (state_d == S_PLL_RST);
    sys_rst_n_d = (state_q == S_RUN) && !restart;
    ready_d     = (state_q == S_RUN) && !restart;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_PLL_RST;
      cause_q     <= CAUSE_POR;
      cnt_q       <= '0;
      count_q     <= 8'd0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      soft_s1_q   <= 1'b0;
      soft_s2_q   <= 1'b0;
      soft_s3_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
      count_q     <= count_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      soft_s1_q   <= soft_s1_d;
      soft_s2_q   <= soft_s2_d;
      soft_s3_q   <= soft_s3_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign rst_cause = cause_q;
  assign rst_count = count_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Self-checking bench for pll_rst_seq against a timeline-based reference model.
module tb_pll_rst_seq;

  localparam int DEB  = 8;
  localparam int PLL  = 4;
  localparam int LOCK = 10;
  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_n = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  pll_rst_seq #(
    .DEBOUNCE_CYC (DEB),
    .PLL_RST_CYC  (PLL),
    .LOCK_WAIT_CYC(LOCK),
    .SYS_HOLD_CYC (HOLD),
    .CNT_W        (18)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_n       (key_n),
    .soft_rst_req(soft_rst_req),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .rst_cause   (rst_cause),
    .rst_count   (rst_count)
  );

  always #5 clk = ~clk;

  // Reference model: input sample history per edge; a sequence is described by
  // its start edge and the edge at which the PLL reset was released.
  int  m_e = 0;
  bit  m_kl[16];
  bit  m_ss[16];
  bit  m_db_low = 1'b0;
  bit  m_press_pend = 1'b0;
  int  m_start = 0;
  int  m_rel = -1;
  int  m_cause = 0;
  int  m_count = 0;
  bit  m_pll = 1'b1;
  bit  m_sys = 1'b0;

  always @(posedge clk) begin
    bit soft_edge, press, rel_ok, flip;
    m_e++;
    if (!resetn) begin
      m_kl[m_e & 15] = 1'b0;
      m_ss[m_e & 15] = 1'b0;
      m_db_low     = 1'b0;
      m_press_pend = 1'b0;
      m_start      = m_e;
      m_rel        = -1;
      m_cause      = 0;
      m_count      = 0;
    end else begin
      m_kl[m_e & 15] = !key_n;
      m_ss[m_e & 15] = soft_rst_req;
      soft_edge = m_ss[(m_e - 2) & 15] && !m_ss[(m_e - 3) & 15];
      press     = m_press_pend;
      rel_ok    = !m_db_low;
      flip = 1'b1;
      for (int i = 0; i < DEB; i++)
        if (m_kl[(m_e - 2 - i) & 15] == m_db_low) flip = 1'b0;
      m_press_pend = 1'b0;
      if (flip) begin
        m_db_low     = !m_db_low;
        m_press_pend = m_db_low;
      end
      if (press || soft_edge) begin
        m_start = m_e;
        m_rel   = -1;
        m_cause = press ? 1 : 2;
        if (m_count < 255) m_count++;
      end else if (m_rel < 0 && m_e >= m_start + PLL && rel_ok) begin
        m_rel = m_e;
      end
    end
    m_pll = (m_rel < 0);
    m_sys = (m_rel >= 0) && (m_e >= m_rel + LOCK + HOLD + 1);
  end

  int compared = 0;
  int mismatched = 0;
  int drop_cnt = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ready !== 1'b1) drop_cnt++;
    if (chk_en) begin
      cmp("model_pll_rst", {7'd0, pll_rst}, {7'd0, m_pll});
      cmp("model_sys_rst_n", {7'd0, sys_rst_n}, {7'd0, m_sys});
      cmp("model_ready", {7'd0, ready}, {7'd0, m_sys});
      cmp("model_rst_cause", {6'd0, rst_cause}, 8'(m_cause));
      cmp("model_rst_count", rst_count, 8'(m_count));
    end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ready !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    if (ready !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL wait_ready: ready=%b still not 1 after %0d cycles", ready, budget);
    end
  endtask

  task automatic wait_pll(input logic lvl, input int budget);
    int n = 0;
    while (pll_rst !== lvl && n < budget) begin
      tick();
      n++;
    end
    if (pll_rst !== lvl) begin
      compared++;
      mismatched++;
      $display("FAIL wait_pll: pll_rst=%b, required %b within %0d cycles", pll_rst, lvl, budget);
    end
  endtask

  typedef struct {
    int key_low;
    int soft_high;
    bit restart;
    int cause;
    int count;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{5,   0,   1'b0, 0, 0};  // short glitch from POR state
    vecs[1] = '{40,  0,   1'b1, 1, 1};  // genuine press
    vecs[2] = '{0,   100, 1'b1, 2, 2};  // soft level held: one restart only
    vecs[3] = '{7,   0,   1'b0, 2, 2};  // one sample short of debounce
    vecs[4] = '{8,   0,   1'b1, 1, 3};  // exactly the debounce length
    vecs[5] = '{0,   1,   1'b1, 2, 4};  // single-cycle soft pulse

    // POR: hold 5 cycles, then check release timing by hand.
    tick();
    chk_en = 1'b1;
    repeat (4) tick();
    cmp("por_pll_rst_in_reset", {7'd0, pll_rst}, 8'd1);
    cmp("por_sys_rst_n_in_reset", {7'd0, sys_rst_n}, 8'd0);
    resetn = 1'b1;
    repeat (3) tick();
    cmp("por_pll_rst_before_4", {7'd0, pll_rst}, 8'd1);
    tick();
    cmp("por_pll_rst_at_4", {7'd0, pll_rst}, 8'd0);
    repeat (13) tick();
    cmp("por_ready_before_18", {7'd0, ready}, 8'd0);
    tick();
    cmp("por_ready_at_18", {7'd0, ready}, 8'd1);
    cmp("por_sys_rst_n_at_18", {7'd0, sys_rst_n}, 8'd1);
    cmp("por_cause", {6'd0, rst_cause}, 8'd0);
    cmp("por_count", rst_count, 8'd0);

    for (int i = 0; i < 6; i++) begin
      wait_ready(300);
      drop_cnt = 0;
      if (vecs[i].key_low > 0) begin
        key_n = 1'b0;
        repeat (vecs[i].key_low) tick();
        key_n = 1'b1;
      end
      if (vecs[i].soft_high > 0) begin
        soft_rst_req = 1'b1;
        repeat (vecs[i].soft_high) tick();
        soft_rst_req = 1'b0;
      end
      repeat (20) tick();
      wait_ready(300);
      cmp("vec_restart", {7'd0, drop_cnt > 0}, {7'd0, vecs[i].restart});
      cmp("vec_cause", {6'd0, rst_cause}, 8'(vecs[i].cause));
      cmp("vec_count", rst_count, 8'(vecs[i].count));
    end

    // Soft restart, then a KEY press and soft edge landing together in S_LOCK_WAIT.
    soft_rst_req = 1'b1;
    wait_pll(1'b1, 20);
    soft_rst_req = 1'b0;
    tick();
    key_n = 1'b0;
    repeat (8) tick();
    soft_rst_req = 1'b1;
    repeat (2) tick();
    cmp("tie_pll_rst_before", {7'd0, pll_rst}, 8'd0);
    tick();
    cmp("tie_pll_rst_after", {7'd0, pll_rst}, 8'd1);
    cmp("tie_sys_rst_n_after", {7'd0, sys_rst_n}, 8'd0);
    cmp("tie_cause", {6'd0, rst_cause}, 8'd1);
    cmp("tie_count", rst_count, 8'd6);
    soft_rst_req = 1'b0;
    repeat (2) tick();
    key_n = 1'b1;
    wait_ready(300);

    // Random key/soft activity, checked cycle by cycle against the model.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          key_n = 1'b0;
          repeat ($urandom_range(1, 20)) tick();
          key_n = 1'b1;
        end
        1: begin
          soft_rst_req = 1'b1;
          repeat ($urandom_range(1, 6)) tick();
          soft_rst_req = 1'b0;
        end
        default: ;
      endcase
      repeat ($urandom_range(0, 30)) tick();
    end
    key_n = 1'b1;
    soft_rst_req = 1'b0;
    repeat (20) tick();

    // 260 soft restarts saturate the counter.
    for (int i = 0; i < 260; i++) begin
      soft_rst_req = 1'b1;
      repeat (2) tick();
      soft_rst_req = 1'b0;
      repeat (2) tick();
    end
    cmp("sat_count", rst_count, 8'd255);
    cmp("sat_cause", {6'd0, rst_cause}, 8'd2);

    // resetn dropped in the middle of S_LOCK_WAIT.
    wait_pll(1'b0, 40);
    repeat (3) tick();
    resetn = 1'b0;
    tick();
    cmp("midrst_pll_rst", {7'd0, pll_rst}, 8'd1);
    cmp("midrst_sys_rst_n", {7'd0, sys_rst_n}, 8'd0);
    cmp("midrst_ready", {7'd0, ready}, 8'd0);
    cmp("midrst_cause", {6'd0, rst_cause}, 8'd0);
    cmp("midrst_count", rst_count, 8'd0);
    repeat (2) tick();
    resetn = 1'b1;
    wait_ready(100);
    cmp("midrst_count_after", rst_count, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
